// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the core-to-AXI master bridge: bus field widths,
// fixed burst encodings, response codes and the bridge FSM state type.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package axi_pkg;

    localparam int AXI_ID_W    = `AXI_ID_BITS;
    localparam int AXI_ADDR_W  = `AXI_ADDR_BITS;
    localparam int AXI_DATA_W  = `AXI_DATA_BITS;
    localparam int AXI_LEN_W   = `AXI_LEN_BITS;
    localparam int AXI_SIZE_W  = `AXI_SIZE_BITS;
    localparam int AXI_BURST_W = `AXI_BURST_BITS;
    localparam int AXI_RESP_W  = `AXI_RESP_BITS;

    localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0]  RESP_DECERR = 2'b11;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_SIZE_W-1:0]  SIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP
    } bridge_state_t;

endpackage

// File: rtl/axi_master_bridge.sv
// Turns a single-beat core request into one AXI4 read (AR/R) or write (AW/W/B)
// transaction, stalling the core until the bus completes.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] MASTER_ID = '0,
    parameter int                  ADDR_BITS = AXI_ADDR_W,
    parameter int                  DATA_BITS = AXI_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [ADDR_BITS-1:0]     core_addr,
    input  logic [DATA_BITS-1:0]     core_wdata,
    input  logic [DATA_BITS/8-1:0]   core_wstrb,
    output logic [DATA_BITS-1:0]     core_rdata,
    output logic                     core_done,
    output logic                     core_err,
    output logic                     core_stall,
    output logic [AXI_ID_W-1:0]      ARID,
    output logic [ADDR_BITS-1:0]     ARADDR,
    output logic [AXI_LEN_W-1:0]     ARLEN,
    output logic [AXI_SIZE_W-1:0]    ARSIZE,
    output logic [AXI_BURST_W-1:0]   ARBURST,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [AXI_ID_W-1:0]      RID,
    input  logic [DATA_BITS-1:0]     RDATA,
    input  logic [AXI_RESP_W-1:0]    RRESP,
    input  logic                     RLAST,
    input  logic                     RVALID,
    output logic                     RREADY,
    output logic [AXI_ID_W-1:0]      AWID,
    output logic [ADDR_BITS-1:0]     AWADDR,
    output logic [AXI_LEN_W-1:0]     AWLEN,
    output logic [AXI_SIZE_W-1:0]    AWSIZE,
    output logic [AXI_BURST_W-1:0]   AWBURST,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [DATA_BITS-1:0]     WDATA,
    output logic [DATA_BITS/8-1:0]   WSTRB,
    output logic                     WLAST,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [AXI_ID_W-1:0]      BID,
    input  logic [AXI_RESP_W-1:0]    BRESP,
    input  logic                     BVALID,
    output logic                     BREADY
);

    bridge_state_t            state_reg, state_next;
    logic [ADDR_BITS-1:0]     addr_reg;
    logic [DATA_BITS-1:0]     wdata_reg;
    logic [DATA_BITS/8-1:0]   wstrb_reg;
    logic [DATA_BITS-1:0]     rdata_reg;
    logic                     we_reg;
    logic                     done_reg;
    logic                     err_reg;
    logic                     stall_reg;
    logic                     accept;
    logic                     r_done;
    logic                     b_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        r_done     = 1'b0;
        b_done     = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        BREADY     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (core_req) begin
                    accept     = 1'b1;
                    state_next = core_we ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_next = ST_RDATA;
            end
            ST_RDATA: begin
                // A beat without RLAST cannot be the answer to a single-beat read; drop it.
                RREADY = 1'b1;
                if (RVALID && RLAST) begin
                    r_done     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) state_next = ST_WDATA;
            end
            ST_WDATA: begin
                WVALID = 1'b1;
                if (WREADY) state_next = ST_WRESP;
            end
            ST_WRESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    b_done     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            stall_reg <= 1'b0;
        end else begin
            done_reg <= r_done | b_done;
            if (accept) begin
                addr_reg  <= core_addr;
                wdata_reg <= core_wdata;
                wstrb_reg <= core_wstrb;
                we_reg    <= core_we;
                stall_reg <= 1'b1;
            end
            if (r_done) begin
                rdata_reg <= RDATA;
                err_reg   <= (RRESP != RESP_OKAY);
                stall_reg <= 1'b0;
            end
            if (b_done) begin
                err_reg   <= (BRESP != RESP_OKAY);
                stall_reg <= 1'b0;
            end
        end
    end

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_reg;
    assign ARLEN   = '0;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_reg;
    assign AWLEN   = '0;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign WDATA   = wdata_reg;
    assign WSTRB   = wstrb_reg;
    assign WLAST   = WVALID;

    assign core_rdata = rdata_reg;
    assign core_done  = done_reg;
    assign core_err   = err_reg;
    // The completion cycle always shows the core an unstalled cycle, even if a held
    // request is being accepted in that same cycle.
    assign core_stall = stall_reg | (accept & ~done_reg);

    // Response IDs are not compared and the latched direction is informational only.
    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, we_reg};

endmodule

// File: tb/tb_axi_master_bridge.sv
// Scoreboard bench for axi_master_bridge: a reactive AXI slave with its own memory,
// a core-side driver, and a monitor comparing each done pulse to a queued expectation.
module tb_axi_master_bridge;
    import axi_pkg::*;

    localparam logic [3:0] MID = 4'h6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_wstrb = '0;
    logic [31:0] core_rdata;
    logic        core_done, core_err, core_stall;
    logic [3:0]  ARID, RID, AWID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;

    always #5 clk = ~clk;

    axi_master_bridge #(.MASTER_ID(MID), .ADDR_BITS(32), .DATA_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata),
        .core_done(core_done), .core_err(core_err), .core_stall(core_stall),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        int          d0;
        int          d1;
        int          d2;
        bit          bogus;
    } txn_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          done_cyc;
    } exp_t;

    txn_t        bus_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] last_rd = '0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [1:0] resp,
                                input int d0, input int d1, input int d2, input bit bogus);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.resp = resp;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.bogus = bogus;
        return t;
    endfunction

    // Reference: completion cycle = accept cycle + fixed phase count + slave wait cycles.
    task automatic commit(input txn_t t);
        exp_t e;
        e.we  = t.we;
        e.err = (t.resp != 2'b00);
        if (t.we) begin
            model_mem[t.addr] = merge(model_rd(t.addr), t.wdata, t.wstrb);
            e.rdata    = last_rd;
            e.done_cyc = cyc + 4 + t.d0 + t.d1 + t.d2;
        end else begin
            e.rdata    = model_rd(t.addr);
            last_rd    = e.rdata;
            e.done_cyc = cyc + 3 + t.d0 + t.d1 + (t.bogus ? 1 : 0);
        end
        exp_q.push_back(e);
        bus_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input txn_t t);
        core_req   = 1'b1;
        core_we    = t.we;
        core_addr  = t.addr;
        core_wdata = t.wdata;
        core_wstrb = t.wstrb;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!core_done && n < 300) begin
            step();
            n++;
        end
        if (!core_done) fail_now("done_timeout", "no core_done within 300 cycles");
    endtask

    task automatic do_txn(input txn_t t);
        if (core_done) step();
        present(t);
        commit(t);
        @(negedge clk);
        chk("stall_accept", {31'd0, core_stall}, 32'd1);
        step();
        core_req = 1'b0;
        wait_done();
    endtask

    // Second request is presented right after the first is accepted and held high.
    task automatic do_pair(input txn_t t1, input txn_t t2);
        if (core_done) step();
        present(t1);
        commit(t1);
        @(negedge clk);
        chk("stall_accept", {31'd0, core_stall}, 32'd1);
        step();
        present(t2);
        wait_done();
        commit(t2);
        step();
        core_req = 1'b0;
        wait_done();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, 31)) << 2;
        t.wdata = $urandom;
        t.wstrb = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 7);
        t.resp  = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
        t.d0    = $urandom_range(0, 3);
        t.d1    = $urandom_range(0, 3);
        t.d2    = $urandom_range(0, 3);
        t.bogus = !t.we && ($urandom_range(0, 5) == 0);
        return t;
    endfunction

    initial begin : slave
        txn_t        cur;
        bit          ar_act, r_act, aw_act, w_act, b_act, bogus_pend;
        int          wait_cnt;
        logic [31:0] word;
        ar_act = 0; r_act = 0; aw_act = 0; w_act = 0; b_act = 0; bogus_pend = 0; wait_cnt = 0;
        cur = mk(0, '0, '0, '0, '0, 0, 0, 0, 0);
        ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0; RRESP = '0; RID = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; BID = '0;
        forever begin
            @(negedge clk);
            ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
            if (!rst) begin
                ar_act = 0; r_act = 0; aw_act = 0; w_act = 0; b_act = 0; bogus_pend = 0;
            end else begin
                chk("aw_w_exclusive", {31'd0, AWVALID & WVALID}, 32'd0);
                if (ARVALID) begin
                    if (!ar_act) begin
                        if (bus_q.size() == 0 || bus_q[0].we) begin
                            fail_now("ar_unexpected", $sformatf("read address %h not requested", ARADDR));
                            cur = mk(0, ARADDR, '0, '0, '0, 0, 0, 0, 0);
                        end else begin
                            cur = bus_q.pop_front();
                        end
                        ar_act = 1;
                        wait_cnt = cur.d0;
                    end
                    chk("araddr", ARADDR, cur.addr);
                    chk("ar_fields", {15'd0, ARID, ARLEN, ARSIZE, ARBURST}, {15'd0, MID, 8'd0, 3'b010, 2'b01});
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        ARREADY = 1; ar_act = 0; r_act = 1; wait_cnt = cur.d1; bogus_pend = cur.bogus;
                    end
                end else if (r_act) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        chk("rready", {31'd0, RREADY}, 32'd1);
                        word = slave_rd(cur.addr);
                        RVALID = 1;
                        RID = ~MID;
                        if (bogus_pend) begin
                            RLAST = 0; RDATA = ~word; RRESP = 2'b00; bogus_pend = 0;
                        end else begin
                            RLAST = 1; RDATA = word; RRESP = cur.resp; r_act = 0;
                        end
                    end
                end
                if (AWVALID) begin
                    if (!aw_act) begin
                        if (bus_q.size() == 0 || !bus_q[0].we) begin
                            fail_now("aw_unexpected", $sformatf("write address %h not requested", AWADDR));
                            cur = mk(1, AWADDR, '0, '0, '0, 0, 0, 0, 0);
                        end else begin
                            cur = bus_q.pop_front();
                        end
                        aw_act = 1;
                        wait_cnt = cur.d0;
                    end
                    chk("awaddr", AWADDR, cur.addr);
                    chk("aw_fields", {15'd0, AWID, AWLEN, AWSIZE, AWBURST}, {15'd0, MID, 8'd0, 3'b010, 2'b01});
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        AWREADY = 1; aw_act = 0; w_act = 1; wait_cnt = cur.d1;
                    end
                end else if (WVALID) begin
                    if (!w_act) fail_now("w_before_aw", "WVALID without a completed AW handshake");
                    else begin
                        chk("wdata", WDATA, cur.wdata);
                        chk("wstrb", {28'd0, WSTRB}, {28'd0, cur.wstrb});
                        chk("wlast", {31'd0, WLAST}, 32'd1);
                        if (wait_cnt > 0) wait_cnt--;
                        else begin
                            WREADY = 1;
                            slave_mem[cur.addr] = merge(slave_rd(cur.addr), WDATA, WSTRB);
                            w_act = 0; b_act = 1; wait_cnt = cur.d2;
                        end
                    end
                end else if (b_act) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        chk("bready", {31'd0, BREADY}, 32'd1);
                        BVALID = 1; BRESP = cur.resp; BID = ~MID; b_act = 0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (core_done) begin
                    chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
                    chk("stall_at_done", {31'd0, core_stall}, 32'd0);
                    if (exp_q.size() == 0) begin
                        fail_now("done_unexpected", "core_done with no outstanding request");
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] cycle %0d done we=%0b rdata=%h err=%0b", cyc, e.we, core_rdata, core_err);
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("core_err", {31'd0, core_err}, {31'd0, e.err});
                        chk(e.we ? "rdata_hold" : "core_rdata", core_rdata, e.rdata);
                    end
                end
                if (ARVALID | RREADY | AWVALID | WVALID | BREADY)
                    chk("stall_busy", {31'd0, core_stall}, 32'd1);
            end
            prev_done = core_done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        txn_t w;
        int   n;
        model_mem[32'h10] = 32'hDEAD_BEEF;
        slave_mem[32'h10] = 32'hDEAD_BEEF;
        rst = 1'b0;
        repeat (3) step();
        chk("rst_valids", {27'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'd0);
        chk("rst_core", {29'd0, core_done, core_err, core_stall}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        rst = 1'b1;
        step();

        do_txn(mk(0, 32'h10, '0, '0, 2'b00, 0, 0, 0, 0));
        do_txn(mk(1, 32'h24, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 0, 0));
        do_txn(mk(0, 32'h24, '0, '0, 2'b00, 0, 0, 0, 0));
        do_txn(mk(0, 32'h10, '0, '0, 2'b10, 0, 0, 0, 0));
        do_txn(mk(0, 32'h10, '0, '0, 2'b00, 0, 0, 0, 0));
        do_pair(mk(1, 32'h100, 32'hCAFE_F00D, 4'b1111, 2'b00, 0, 0, 0, 0),
                mk(0, 32'h100, '0, '0, 2'b00, 0, 0, 0, 0));
        do_txn(mk(0, 32'h44, '0, '0, 2'b00, 0, 5, 0, 0));
        do_txn(mk(0, 32'h48, '0, '0, 2'b00, 1, 0, 0, 1));
        do_txn(mk(1, 32'h48, 32'hFFFF_FFFF, 4'b0000, 2'b11, 0, 0, 2, 0));
        do_txn(mk(0, 32'h48, '0, '0, 2'b00, 0, 0, 0, 0));

        // Abort a write while WVALID is waiting; the slave memory and model stay untouched.
        step();
        w = mk(1, 32'h40, 32'hBAD0_BAD0, 4'b1111, 2'b00, 0, 8, 0, 0);
        present(w);
        bus_q.push_back(w);
        step();
        core_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!WVALID && n < 20);
        if (!WVALID) fail_now("wdata_timeout", "write never reached the data phase");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valids", {27'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'd0);
        chk("abort_core", {30'd0, core_done, core_stall}, 32'd0);
        chk("abort_rdata", core_rdata, 32'd0);
        last_rd = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        step();
        do_txn(mk(0, 32'h40, '0, '0, 2'b00, 0, 0, 0, 0));
        do_txn(mk(1, 32'h40, 32'h0BAD_F00D, 4'b1010, 2'b00, 0, 0, 0, 0));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_pair(rand_txn(), rand_txn());
            else begin
                repeat ($urandom_range(0, 2)) step();
                do_txn(rand_txn());
            end
        end

        repeat (5) step();
        chk("exp_drained", exp_q.size(), 32'd0);
        chk("bus_drained", bus_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Upstream neighbour of the SRAM slave wrapper. Converts the CPU core's simple single-beat memory request interface into AXI4 master transactions (AR/R or AW/W/B) toward the bus interconnect and SRAM slave.
- One instance per CPU port (instruction fetch, data).
- Holds the core stalled until the bus transaction completes, then returns read data or write completion with a one-cycle done pulse.

Parameters:
- MASTER_ID, 4'd0, constant value driven on ARID/AWID (`AXI_ID_BITS wide)
- ADDR_BITS, 32, core address width (equals `AXI_ADDR_BITS)
- DATA_BITS, 32, core data width (equals `AXI_DATA_BITS)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-low reset
- core_req  in  1  request valid (level); sampled only in IDLE
- core_we  in  1  1 = write, 0 = read
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_wstrb  in  4  byte enables, active-high
- core_rdata  out  32  read data, valid when core_done & ~core_we_q
- core_done  out  1  one-cycle completion pulse
- core_err  out  1  RRESP/BRESP != OKAY, valid with core_done
- core_stall  out  1  high from acceptance until the cycle of core_done
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  out; ARREADY  in  (AXI read address)
- RID, RDATA, RRESP, RLAST, RVALID  in; RREADY  out  (AXI read data)
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  out; AWREADY  in  (AXI write address)
- WDATA, WSTRB, WLAST, WVALID  out; WREADY  in  (AXI write data)
- BID, BRESP, BVALID  in; BREADY  out  (AXI write response)

Behaviour:
- Reset: synchronous, active-low, clocked on posedge clk when rst==0. FSM goes to IDLE. All VALID/READY outputs, core_done, core_err and core_stall are 0. core_rdata and the latched address/data/strobe registers are 0. Reset mid-transaction aborts silently with no done pulse.
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE -> RADDR or WADDR on core_req (~core_we / core_we). In that cycle, core_addr, core_wdata, core_wstrb and core_we are latched into registers. core_stall is asserted combinationally in the accept cycle and registered afterwards.
- Constant AXI fields: ARLEN/AWLEN=0, ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01 (INCR), WLAST=1 whenever WVALID. IDs are MASTER_ID.
- RADDR: ARVALID=1, ARADDR=latched addr. It must stay asserted and stable until ARREADY. On the handshake -> RDATA.
- RDATA: RREADY=1. On RVALID&RLAST: capture RDATA into core_rdata, set core_err=(RRESP!=2'b00), pulse core_done, go to IDLE. RVALID without RLAST (protocol violation for LEN=0) is consumed and ignored.
- WADDR: AWVALID=1, AWADDR=latched addr. On AWREADY -> WDATA. AW and W are never concurrent.
- WDATA: WVALID=1, WDATA and WSTRB come from the latched values. On WREADY -> WRESP.
- WRESP: BREADY=1. On BVALID: core_err=(BRESP!=2'b00), pulse core_done, go to IDLE.
- Latency with a zero-wait slave:
  - read: accept cycle T, AR handshake T+1, R beat T+2, done T+2 (registered pulse visible T+3)
  - write: done at T+3 (registered pulse visible T+4)
- core_done is registered, high exactly one cycle. core_stall deasserts in that same cycle.
- Back-to-back: core_req sampled in the cycle after core_done may be accepted immediately. No request is accepted outside IDLE; core_req there is ignored and must be held by the core.
- RID/BID mismatch vs MASTER_ID is not checked. core_rdata holds its last value until the next read completes.
- core_wstrb=0 is still issued as a full AXI write with WSTRB=0.

Decomposition:
- Shared package axi_pkg:
  - state enum typedef for this FSM
  - RESP constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11)
  - BURST_INCR and SIZE_WORD constants
  - reuses existing AXI width macros
- No sub-module; a single FSM with a request-latch register bank.

Test Plan:
- Zero-wait read: core_req=1, we=0, addr=32'h0000_0010; slave returns RDATA=32'hDEAD_BEEF, RRESP=0 -> ARADDR=0x10, ARLEN=0, core_rdata=DEADBEEF, core_done exactly one cycle at T+3, core_err=0.
- Write with strobes: addr=0x24, wdata=32'h1234_5678, wstrb=4'b0011; AWREADY delayed 3 cycles -> AWVALID held stable 4 cycles, WVALID only after AW handshake, WLAST=1, WSTRB=0011, done after BVALID.
- Error response: read with RRESP=2'b10 -> core_done=1 with core_err=1; the next OKAY read clears core_err=0.
- Back-to-back: write 0x100 then read 0x100 with core_req held high -> second AR issued the cycle after first done, no lost or duplicated request, stall continuous except one IDLE cycle.
- Reset mid-write: rst=0 while in WDATA -> next cycle all VALIDs=0, state IDLE, no core_done pulse; a subsequent read completes normally.
- Handshake stall: RVALID delayed 5 cycles with RREADY=1 throughout -> core_stall high for the whole duration, no done until the RLAST beat.
